// File: rtl/rgb_csc_packer.sv
// BT.601 YUV 4:4:4 -> RGB888 converter with a 3-stage pipeline, packing RGB bytes
// big-endian into 16-bit SRAM words written sequentially from BASE_ADDR.
module rgb_csc_packer #(
  parameter logic [17:0] BASE_ADDR  = 18'd146944,
  parameter int          NUM_PIXELS = 76800
) (
  input  logic        Clock_i,
  input  logic        Resetn_i,
  input  logic        start_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  in_Y_i,
  input  logic [7:0]  in_U_i,
  input  logic [7:0]  in_V_i,
  output logic        wr_en_o,
  output logic [17:0] wr_addr_o,
  output logic [15:0] wr_data_o,
  input  logic        wr_grant_i,
  output logic        busy_o,
  output logic        done_o
);
  localparam int NUM_WORDS = NUM_PIXELS * 3 / 2;
  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam logic [CW-1:0] PIX_MAX   = CW'(NUM_PIXELS);
  localparam logic [CW-1:0] WORD_LAST = CW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [CW-1:0] pix_cnt_q, pix_cnt_d, word_cnt_q, word_cnt_d;
  logic [17:0]   wr_addr_q, wr_addr_d;

  logic [2:0]        vld_q;
  logic signed [8:0] y_q, u_q, v_q;
  logic signed [31:0] p_yr_q, p_rv_q, p_gu_q, p_gv_q, p_bu_q;
  logic [7:0]        r_q, g_q, b_q;

  logic              odd_q, odd_d;
  logic [7:0]        held_q, held_d;
  logic [1:0][15:0]  buf_q, buf_d;
  logic [1:0]        cnt_q, cnt_d;

  logic       pop, take, stall, can_take, accept;
  logic [1:0] free;

  function automatic logic [7:0] clip8(input logic signed [31:0] s);
    logic signed [31:0] sh;
    sh = s >>> 16;
    if (sh < 0)               clip8 = 8'd0;
    else if (sh > 32'sd255)   clip8 = 8'hFF;
    else                      clip8 = sh[7:0];
  endfunction

  assign wr_en_o   = (cnt_q != 2'd0);
  assign wr_data_o = buf_q[0];
  assign wr_addr_o = wr_addr_q;
  assign busy_o    = (state_q == RUN);
  assign done_o    = (state_q == DONE);

  // A same-cycle pop frees an entry, which is what sustains 3 words per 2 pixels.
  assign pop      = wr_en_o && wr_grant_i;
  assign free     = 2'd2 - cnt_q + {1'b0, pop};
  assign can_take = odd_q ? (free == 2'd2) : (free != 2'd0);
  assign take     = vld_q[2] && can_take;
  assign stall    = vld_q[2] && !can_take;

  assign in_ready_o = (state_q == RUN) && (pix_cnt_q < PIX_MAX) && !stall;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    word_cnt_d = word_cnt_q;
    wr_addr_d  = wr_addr_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d    = RUN;
        pix_cnt_d  = '0;
        word_cnt_d = '0;
        wr_addr_d  = BASE_ADDR;
      end
      RUN: begin
        if (accept) pix_cnt_d = pix_cnt_q + 1'b1;
        if (pop) begin
          wr_addr_d  = wr_addr_q + 18'd1;
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == WORD_LAST) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    odd_d  = odd_q;
    held_d = held_q;
    if (pop) begin
      buf_d[0] = buf_q[1];
      cnt_d    = cnt_q - 2'd1;
    end
    if (take) begin
      if (!odd_q) begin
        buf_d[cnt_d[0]] = {r_q, g_q};
        cnt_d           = cnt_d + 2'd1;
        held_d          = b_q;
      end else begin
        buf_d[0] = {held_q, r_q};
        buf_d[1] = {g_q, b_q};
        cnt_d    = 2'd2;
      end
      odd_d = !odd_q;
    end
    if (state_q == IDLE && start_i) odd_d = 1'b0;
  end

  always_ff @(posedge Clock_i or negedge Resetn_i) begin
    if (!Resetn_i) begin
      state_q    <= IDLE;
      pix_cnt_q  <= '0;
      word_cnt_q <= '0;
      wr_addr_q  <= BASE_ADDR;
      buf_q      <= '0;
      cnt_q      <= 2'd0;
      odd_q      <= 1'b0;
      held_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      word_cnt_q <= word_cnt_d;
      wr_addr_q  <= wr_addr_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      odd_q      <= odd_d;
      held_q     <= held_d;
    end
  end

  // All three stages advance together; a stall freezes the whole pipe.
  always_ff @(posedge Clock_i or negedge Resetn_i) begin
    if (!Resetn_i) begin
      vld_q  <= 3'b000;
      y_q    <= '0;
      u_q    <= '0;
      v_q    <= '0;
      p_yr_q <= '0;
      p_rv_q <= '0;
      p_gu_q <= '0;
      p_gv_q <= '0;
      p_bu_q <= '0;
      r_q    <= 8'd0;
      g_q    <= 8'd0;
      b_q    <= 8'd0;
    end else if (!stall) begin
      vld_q  <= {vld_q[1:0], accept};
      y_q    <= $signed({1'b0, in_Y_i}) - 9'sd16;
      u_q    <= $signed({1'b0, in_U_i}) - 9'sd128;
      v_q    <= $signed({1'b0, in_V_i}) - 9'sd128;
      p_yr_q <= 32'(y_q) * 32'sd76284;
      p_rv_q <= 32'(v_q) * 32'sd104595;
      p_gu_q <= 32'(u_q) * 32'sd25624;
      p_gv_q <= 32'(v_q) * 32'sd53281;
      p_bu_q <= 32'(u_q) * 32'sd132251;
      r_q    <= clip8(p_yr_q + p_rv_q);
      g_q    <= clip8(p_yr_q - p_gu_q - p_gv_q);
      b_q    <= clip8(p_yr_q + p_bu_q);
    end
  end

endmodule
